// File: rtl/weight_bit_serializer.sv
// -----------------------------------------------------------------------------
// weight_bit_serializer
//
// Purpose:
//   Takes one vector of VEC_LENGTH two's-complement weights per handshake and
//   streams it to the bit-serial MAC array as sign-magnitude bit-columns.
//   The most significant column is sent first. A column whose magnitude bit
//   is zero in every lane is skipped, so bit-sparse vectors take fewer beats.
//   The MAC adds (+/-act << out_column_idx) for each beat it receives.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   in_valid        a weight vector is present on w_in
//   in_ready        a vector can be accepted this cycle
//   w_in            VEC_LENGTH x DATA_WIDTH signed weights (lane 0 in the LSBs)
//   out_valid       the beat on out_* is valid
//   out_ready       downstream consumes the current beat this cycle
//   out_sign        per-lane sign (1 = negative weight), constant per vector
//   out_w_bit       per-lane magnitude bit at out_column_idx
//   out_column_idx  bit position of the current beat
//   out_first       first beat of a vector
//   out_last        final beat of a vector
//
// in_ready depends combinationally on out_ready so that a new vector can be
// loaded on the same edge that retires the last beat of the previous one.
// out_* are driven only from registers, so in_valid has no combinational
// path to any output.
// -----------------------------------------------------------------------------
module weight_bit_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8,
  localparam int COL_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [VEC_LENGTH-1:0]                 out_sign,
  output logic [VEC_LENGTH-1:0]                 out_w_bit,
  output logic [COL_W-1:0]                      out_column_idx,
  output logic                                  out_first,
  output logic                                  out_last
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SERIAL = 1'b1;

  logic [0:0]                            state_q;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mag_q;
  logic [VEC_LENGTH-1:0]                 sign_q;
  logic [DATA_WIDTH-1:0]                 rem_q;
  logic                                  first_q;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mag_in;
  logic [VEC_LENGTH-1:0]                 sign_in;
  logic [DATA_WIDTH-1:0]                 or_in;
  logic [DATA_WIDTH-1:0]                 rem_in;

  logic [COL_W-1:0]                      col_idx;
  logic [DATA_WIDTH-1:0]                 col_mask;
  logic                                  is_last;
  logic                                  serial;
  logic                                  beat_done;
  logic                                  accept;

  // Sign-magnitude conversion of the incoming vector. Negating the most
  // negative value wraps back to itself, which is exactly 2^(DATA_WIDTH-1)
  // when read as unsigned, so no special case is needed. An all-zero vector
  // still gets one column-0 beat so the consumer always sees first/last.
  always_comb begin
    or_in   = '0;
    sign_in = '0;
    mag_in  = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      sign_in[j] = w_in[j][DATA_WIDTH-1];
      mag_in[j]  = sign_in[j] ? -w_in[j] : w_in[j];
      or_in      = or_in | mag_in[j];
    end
    rem_in = (or_in == '0) ? DATA_WIDTH'(1) : or_in;
  end

  // The highest remaining column is the next one to send; the loop keeps the
  // last (highest) set bit it sees.
  always_comb begin
    col_idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (rem_q[i]) begin
        col_idx = COL_W'(i);
      end
    end
    col_mask = DATA_WIDTH'(1) << col_idx;
    is_last  = (rem_q != '0) && ((rem_q & (rem_q - DATA_WIDTH'(1))) == '0);
  end

  // Beat fields are gated by SERIAL so that every output reads 0 when idle,
  // even though mag_q/sign_q keep the previous vector's contents.
  always_comb begin
    serial         = (state_q == SERIAL);
    out_valid      = serial;
    out_column_idx = serial ? col_idx : '0;
    out_sign       = serial ? sign_q : '0;
    out_first      = serial & first_q;
    out_last       = serial & is_last;
    out_w_bit      = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      out_w_bit[j] = serial & mag_q[j][col_idx];
    end
  end

  always_comb begin
    beat_done = serial & out_ready;
    in_ready  = !serial | (beat_done & is_last);
    accept    = in_valid & in_ready;
  end

  // A new vector can only be accepted in IDLE or on the edge that retires the
  // last beat, so loading it simply overrides the end-of-vector bookkeeping
  // and the stream continues with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      sign_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else if (accept) begin
      state_q <= SERIAL;
      mag_q   <= mag_in;
      sign_q  <= sign_in;
      rem_q   <= rem_in;
      first_q <= 1'b1;
    end else if (beat_done) begin
      rem_q   <= rem_q & ~col_mask;
      first_q <= 1'b0;
      if (is_last) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_weight_bit_serializer
//
// Directed bench for weight_bit_serializer at the default 8 x 8 configuration.
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// 1-2 time units after the edge. A small MAC model accumulates the received
// beats so the bit-serial product can be compared against a hand-computed dot
// product.
// -----------------------------------------------------------------------------
module tb_weight_bit_serializer;

  localparam int DW = 8;
  localparam int VL = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [VL-1:0][DW-1:0] w_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [VL-1:0]         out_sign;
  logic [VL-1:0]         out_w_bit;
  logic [2:0]            out_column_idx;
  logic                  out_first;
  logic                  out_last;

  int num_vectors     = 0;
  int num_miscompares = 0;
  int acts [VL];
  int mac_acc;

  localparam logic [VL-1:0][DW-1:0] ZERO_VEC  = '0;
  localparam logic [VL-1:0][DW-1:0] ONES_VEC  = {VL{8'h01}};
  localparam logic [VL-1:0][DW-1:0] MIN_VEC   = {56'h0, 8'h80};
  localparam logic [VL-1:0][DW-1:0] FIVE_VEC  = {48'h0, 8'hFD, 8'h05};
  localparam logic [VL-1:0][DW-1:0] SIXTY_VEC = {VL{8'h40}};

  weight_bit_serializer #(
    .DATA_WIDTH(DW),
    .VEC_LENGTH(VL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .w_in           (w_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sign       (out_sign),
    .out_w_bit      (out_w_bit),
    .out_column_idx (out_column_idx),
    .out_first      (out_first),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [VL-1:0][DW-1:0] w,
                               input logic ready);
    in_valid  = valid;
    w_in      = w;
    out_ready = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_vectors++;
    assert (observed === expected) else begin
      num_miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [2:0] col,
                           input logic [VL-1:0] wbit, input logic [VL-1:0] sign,
                           input logic first, input logic last);
    checkOutput({tag, "/valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "/col"},   32'(out_column_idx), 32'(col));
    checkOutput({tag, "/wbit"},  32'(out_w_bit), 32'(wbit));
    checkOutput({tag, "/sign"},  32'(out_sign), 32'(sign));
    checkOutput({tag, "/first"}, 32'(out_first), 32'(first));
    checkOutput({tag, "/last"},  32'(out_last), 32'(last));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "/col"},   32'(out_column_idx), 32'd0);
    checkOutput({tag, "/wbit"},  32'(out_w_bit), 32'd0);
    checkOutput({tag, "/sign"},  32'(out_sign), 32'd0);
    checkOutput({tag, "/first"}, 32'(out_first), 32'd0);
    checkOutput({tag, "/last"},  32'(out_last), 32'd0);
  endtask

  // Present a vector, confirm it is accepted, and leave the bench sampling
  // the first beat's cycle with in_valid dropped.
  task automatic acceptVector(input string tag, input logic [VL-1:0][DW-1:0] w);
    applyStimulus(1'b1, w, 1'b1);
    checkOutput({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, ZERO_VEC, 1'b1);
  endtask

  task automatic macAccumulate();
    for (int j = 0; j < VL; j++) begin
      if (out_w_bit[j]) begin
        if (out_sign[j]) mac_acc -= acts[j] << out_column_idx;
        else             mac_acc += acts[j] << out_column_idx;
      end
    end
  endtask

  initial begin
    for (int j = 0; j < VL; j++) acts[j] = 0;
    acts[0] = 7;
    acts[1] = 11;
    mac_acc = 0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w_in      = '0;

    // Reset state
    tick();
    tick();
    checkAllZero("rst");
    reset = 1'b0;
    applyStimulus(1'b0, ZERO_VEC, 1'b1);
    checkOutput("rst/in_ready", 32'(in_ready), 32'd1);
    tick();

    // All lanes +1: single column-0 beat
    acceptVector("ones", ONES_VEC);
    checkBeat("ones", 3'd0, 8'hFF, 8'h00, 1'b1, 1'b1);
    checkOutput("ones/in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("ones/idle_valid", 32'(out_valid), 32'd0);
    checkOutput("ones/idle_ready", 32'(in_ready), 32'd1);

    // Lane0 = -128: magnitude is only the MSB
    acceptVector("min", MIN_VEC);
    checkBeat("min", 3'd7, 8'h01, 8'h01, 1'b1, 1'b1);
    tick();
    checkOutput("min/idle_valid", 32'(out_valid), 32'd0);

    // 5 / -3: three beats, MAC result 5*7 - 3*11 = 2
    acceptVector("mac", FIVE_VEC);
    checkBeat("mac/c2", 3'd2, 8'h01, 8'h02, 1'b1, 1'b0);
    checkOutput("mac/c2_in_ready", 32'(in_ready), 32'd0);
    macAccumulate();
    tick();
    checkBeat("mac/c1", 3'd1, 8'h02, 8'h02, 1'b0, 1'b0);
    macAccumulate();
    tick();
    checkBeat("mac/c0", 3'd0, 8'h03, 8'h02, 1'b0, 1'b1);
    checkOutput("mac/c0_in_ready", 32'(in_ready), 32'd1);
    macAccumulate();
    tick();
    checkOutput("mac/idle_valid", 32'(out_valid), 32'd0);
    checkOutput("mac/result", 32'(mac_acc), 32'd2);

    // All-zero vector: exactly one column-0 beat
    acceptVector("zero", ZERO_VEC);
    checkBeat("zero", 3'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("zero/idle_valid", 32'(out_valid), 32'd0);

    // Stall for 3 cycles on the column-1 beat
    acceptVector("stall", FIVE_VEC);
    checkBeat("stall/c2", 3'd2, 8'h01, 8'h02, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      applyStimulus(1'b0, ZERO_VEC, 1'b0);
      checkBeat("stall/hold", 3'd1, 8'h02, 8'h02, 1'b0, 1'b0);
      checkOutput("stall/hold_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    applyStimulus(1'b0, ZERO_VEC, 1'b1);
    checkBeat("stall/c1", 3'd1, 8'h02, 8'h02, 1'b0, 1'b0);
    checkOutput("stall/c1_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkBeat("stall/c0", 3'd0, 8'h03, 8'h02, 1'b0, 1'b1);
    checkOutput("stall/c0_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("stall/idle_valid", 32'(out_valid), 32'd0);

    // Back-to-back: all-64 vector accepted on the last beat of 5/-3
    acceptVector("b2b", FIVE_VEC);
    checkBeat("b2b/c2", 3'd2, 8'h01, 8'h02, 1'b1, 1'b0);
    tick();
    checkBeat("b2b/c1", 3'd1, 8'h02, 8'h02, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, SIXTY_VEC, 1'b1);
    checkBeat("b2b/c0", 3'd0, 8'h03, 8'h02, 1'b0, 1'b1);
    checkOutput("b2b/c0_in_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, ZERO_VEC, 1'b1);
    checkBeat("b2b/next", 3'd6, 8'hFF, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("b2b/idle_valid", 32'(out_valid), 32'd0);

    // Reset mid-vector abandons it
    acceptVector("mrst", FIVE_VEC);
    checkBeat("mrst/c2", 3'd2, 8'h01, 8'h02, 1'b1, 1'b0);
    tick();
    checkBeat("mrst/c1", 3'd1, 8'h02, 8'h02, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkAllZero("mrst/rst");
    reset = 1'b0;
    applyStimulus(1'b0, ZERO_VEC, 1'b1);
    checkOutput("mrst/in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("mrst/no_beat", 32'(out_valid), 32'd0);
    tick();
    checkOutput("mrst/no_beat2", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/weight_bit_serializer.md
Name: weight_bit_serializer

Overview:
- Feeds the bit-serial MAC array.
- Accepts one vector of VEC_LENGTH signed weights per handshake and converts each weight to sign-magnitude form.
- Streams the vector out one bit-column per beat as per-lane sign and w_bit plus a column_idx, MSB column first.
- Columns whose magnitude bit is zero in every lane are skipped, so bit-sparse weight vectors finish in fewer cycles. The downstream MAC accumulates (±act << column_idx) only for the beats it receives.

Parameters:
- DATA_WIDTH, 8, weight width in bits. The column index width is COL_W = $clog2(DATA_WIDTH), which is 3 at the default.
- VEC_LENGTH, 8, number of lanes (weights per vector).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  weight vector present
- in_ready  output  1  block can accept a vector this cycle
- w_in  input  [VEC_LENGTH] x DATA_WIDTH signed  weight vector
- out_valid  output  1  beat valid
- out_ready  input  1  downstream consumes the beat this cycle
- out_sign  output  [VEC_LENGTH] x 1  1 = weight negative
- out_w_bit  output  [VEC_LENGTH] x 1  magnitude bit of each lane at out_column_idx
- out_column_idx  output  COL_W  bit position of the current beat
- out_first  output  1  first beat of a vector
- out_last  output  1  final beat of a vector

Behaviour:
- States: IDLE, SERIAL.
- Reset (synchronous, active-high):
  - state = IDLE.
  - Internal magnitude, sign and remaining-column-mask registers are cleared.
  - All outputs read 0: out_valid, out_sign, out_w_bit, out_column_idx, out_first, out_last.
  - Reset asserted in SERIAL abandons the vector; no further beats are emitted for it.
- Beat completion: a beat completes only when out_valid && out_ready.
- in_ready:
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - Acceptance occurs when in_valid && in_ready.
- On acceptance:
  - sign_q[j] = w_in[j][DATA_WIDTH-1].
  - mag_q[j] = |w_in[j]| as a DATA_WIDTH-bit unsigned value. For -2^(DATA_WIDTH-1) the magnitude is 2^(DATA_WIDTH-1), i.e. only the MSB is set; no saturation is applied.
  - rem_q = bitwise OR of all mag_q[j]. If the result is 0, rem_q = 1 instead, forcing a single column-0 beat with all w_bit = 0.
  - first_q = 1.
  - Next state is SERIAL.
- Latency: a vector accepted at clock edge N presents its first beat in the cycle after edge N.
- In SERIAL, out_valid = 1 and the beat fields are:
  - out_column_idx = index of the highest set bit of rem_q.
  - out_w_bit[j] = mag_q[j][out_column_idx].
  - out_sign[j] = sign_q[j], constant for the whole vector.
  - out_first = first_q.
  - out_last = 1 iff rem_q has exactly one bit set.
- On a completed beat:
  - Clear the current column bit in rem_q and set first_q = 0.
  - If out_last, return to IDLE, unless a new vector is accepted on the same edge (back-to-back). In that case, load the new vector and stay in SERIAL with no bubble cycle.
- Stall: while out_valid && !out_ready, every output holds stable and in_ready = 0.
- Beats per vector = popcount(OR of magnitudes), minimum 1, maximum DATA_WIDTH.
- Downstream pairing: the MAC registers act one cycle before use. The consumer must therefore present act for a vector one cycle ahead of that vector's out_first beat. This block does not drive act.
- No combinational path from in_valid to out_*. in_ready depends combinationally on out_ready.

Test Plan:
- All lanes = +1 → one beat: column 0, w_bit = all 1, sign = all 0, first = last = 1; in_ready returns to 1 after the beat.
- Lane0 = -128, other lanes = 0 → one beat: column 7, w_bit[0] = 1, sign[0] = 1, other w_bit = 0, first = last = 1.
- Lane0 = 5, lane1 = -3, others 0 → three beats (all with sign[1] = 1):
  - column 2: w_bit0 = 1, w_bit1 = 0
  - column 1: w_bit0 = 0, w_bit1 = 1
  - column 0: w_bit0 = 1, w_bit1 = 1, last = 1
  - The bench MAC accumulates 5·a0 - 3·a1.
- All-zero vector → exactly one beat: column 0, all w_bit = 0, first = last = 1.
- out_ready low for 3 cycles during the column-1 beat of the 5/-3 vector → beat fields held unchanged and in_ready = 0 throughout; sequencing resumes correctly once out_ready rises.
- Back-to-back: second vector (all lanes = 64) held valid during the last beat of the first vector → accepted on that edge; the next cycle shows column 6, first = 1, with no idle gap.
- Reset: assert reset mid-vector → outputs all 0 on the next cycle, state IDLE, in_ready = 1 after reset deasserts.
